// File: rtl/vc_fifo_if.sv
// rtl/vc_fifo_if.sv - write/read/status bundle of the multi-VC input buffer.
interface vc_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int NUM_VC     = 2
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

    logic                       wr_en;
    logic [VW-1:0]              wr_vc;
    logic [DATA_WIDTH-1:0]      din;
    logic                       rd_en;
    logic [VW-1:0]              rd_vc;
    logic [DATA_WIDTH-1:0]      dout;
    logic                       dout_vld;
    logic [NUM_VC-1:0]          full;
    logic [NUM_VC-1:0]          empty;
    logic [NUM_VC-1:0]          almost_full;
    logic [NUM_VC*(AW+1)-1:0]   count;
    logic                       ovf_err;
    logic                       udf_err;
    logic                       clr_err;

    modport master (
        output wr_en, wr_vc, din, rd_en, rd_vc, clr_err,
        input  dout, dout_vld, full, empty, almost_full, count, ovf_err, udf_err
    );

    modport slave (
        input  wr_en, wr_vc, din, rd_en, rd_vc, clr_err,
        output dout, dout_vld, full, empty, almost_full, count, ovf_err, udf_err
    );
endinterface

// File: rtl/vc_fifo.sv
// rtl/vc_fifo.sv - NUM_VC circular-buffer FIFOs sharing one write and one read port.
// VC_FIFO_FWFT_EN selects first-word-fall-through reads instead of a registered read.
module vc_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int NUM_VC     = 2,
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic     clk,
    input  logic     rst_n,
    vc_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem    [NUM_VC][DEPTH];
    logic [AW-1:0]         r_wr_ptr [NUM_VC];
    logic [AW-1:0]         r_rd_ptr [NUM_VC];
    logic [CW-1:0]         r_count  [NUM_VC];
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_wr_vc_ok;
    logic                  w_rd_vc_ok;
    logic [VW-1:0]         w_wr_idx;
    logic [VW-1:0]         w_rd_idx;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [NUM_VC-1:0]     w_full;
    logic [NUM_VC-1:0]     w_empty;
    logic [NUM_VC-1:0]     w_af;
    logic [NUM_VC-1:0]     w_inc;
    logic [NUM_VC-1:0]     w_dec;
    logic [DATA_WIDTH-1:0] w_head;

    // Out-of-range VC indices are folded to 0 so array selects stay legal; the request itself is refused.
    assign w_wr_vc_ok = 32'(bus.wr_vc) < NUM_VC;
    assign w_rd_vc_ok = 32'(bus.rd_vc) < NUM_VC;
    assign w_wr_idx   = w_wr_vc_ok ? bus.wr_vc : '0;
    assign w_rd_idx   = w_rd_vc_ok ? bus.rd_vc : '0;

    always_comb begin
        w_full  = '0;
        w_empty = '0;
        w_af    = '0;
        w_inc   = '0;
        w_dec   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            w_full[v]  = (r_count[v] == CW'(DEPTH));
            w_empty[v] = (r_count[v] == '0);
            w_af[v]    = (r_count[v] >= CW'(AF_LEVEL));
        end
        w_wr_acc = bus.wr_en && w_wr_vc_ok && !w_full[w_wr_idx];
        w_rd_acc = bus.rd_en && w_rd_vc_ok && !w_empty[w_rd_idx];
        for (int v = 0; v < NUM_VC; v++) begin
            w_inc[v] = w_wr_acc && (w_wr_idx == VW'(v));
            w_dec[v] = w_rd_acc && (w_rd_idx == VW'(v));
        end
    end

    assign w_head          = r_mem[w_rd_idx][r_rd_ptr[w_rd_idx]];
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almost_full = w_af;
    assign bus.ovf_err     = r_ovf;
    assign bus.udf_err     = r_udf;

    for (genvar g = 0; g < NUM_VC; g++) begin : g_count
        assign bus.count[g*CW +: CW] = r_count[g];
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_idx][r_wr_ptr[w_wr_idx]] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_count[v]  <= '0;
            end
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (w_inc[v]) r_wr_ptr[v] <= r_wr_ptr[v] + AW'(1);
                if (w_dec[v]) r_rd_ptr[v] <= r_rd_ptr[v] + AW'(1);
                if (w_inc[v] && !w_dec[v]) r_count[v] <= r_count[v] + CW'(1);
                else if (w_dec[v] && !w_inc[v]) r_count[v] <= r_count[v] - CW'(1);
            end
            // A new error in the same cycle as clr_err wins.
            if (bus.wr_en && !w_wr_acc) r_ovf <= 1'b1;
            else if (bus.clr_err)       r_ovf <= 1'b0;
            if (bus.rd_en && !w_rd_acc) r_udf <= 1'b1;
            else if (bus.clr_err)       r_udf <= 1'b0;
        end
    end

`ifdef VC_FIFO_FWFT_EN
    assign bus.dout     = w_head;
    assign bus.dout_vld = w_rd_vc_ok && !w_empty[w_rd_idx];
`else
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= w_rd_acc;
            if (w_rd_acc) r_dout <= w_head;
        end
    end

    assign bus.dout     = r_dout;
    assign bus.dout_vld = r_dout_vld;
`endif
endmodule

// File: tb/tb_vc_fifo.sv
// tb/tb_vc_fifo.sv - queue-model bench for vc_fifo: directed plan plus random traffic.
module tb_vc_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int NV    = 2;
    localparam int AF    = DEPTH - 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vc_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(NV)) bus ();
    vc_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(NV), .AF_LEVEL(AF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic cmp_en = 1'b0;

    logic [DW-1:0] mq [NV][$];
    logic [DW-1:0] m_dout;
    logic          m_vld;
    logic          m_ovf;
    logic          m_udf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) mq[v].delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_step(input logic we, input int wvc, input logic [DW-1:0] d,
                              input logic re, input int rvc, input logic clr);
        logic wr_ok, rd_ok;
        wr_ok = we && (wvc < NV) && (mq[wvc].size() < DEPTH);
        rd_ok = re && (rvc < NV) && (mq[rvc].size() > 0);
        m_vld = rd_ok;
        if (rd_ok) m_dout = mq[rvc].pop_front();
        if (wr_ok) mq[wvc].push_back(d);
        if (we && !wr_ok)  m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (re && !rd_ok)  m_udf = 1'b1;
        else if (clr)      m_udf = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.wr_en   = 1'b0;
        bus.wr_vc   = '0;
        bus.din     = '0;
        bus.rd_en   = 1'b0;
        bus.rd_vc   = '0;
        bus.clr_err = 1'b0;
    endtask

    task automatic cyc(input logic we, input int wvc, input logic [DW-1:0] d,
                       input logic re, input int rvc, input logic clr);
        bus.wr_en   = we;
        bus.wr_vc   = 1'(wvc);
        bus.din     = d;
        bus.rd_en   = re;
        bus.rd_vc   = 1'(rvc);
        bus.clr_err = clr;
        @(posedge clk);
        model_step(we, wvc, d, re, rvc, clr);
        @(negedge clk);
        #1;
        idle_inputs();
    endtask

    function automatic logic [CW-1:0] cnt(input int v);
        return bus.count[v*CW +: CW];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int v = 0; v < NV; v++) begin
                chk($sformatf("count%0d", v), 64'(cnt(v)), 64'(mq[v].size()));
                chk($sformatf("full%0d", v), 64'(bus.full[v]), 64'(mq[v].size() == DEPTH));
                chk($sformatf("empty%0d", v), 64'(bus.empty[v]), 64'(mq[v].size() == 0));
                chk($sformatf("afull%0d", v), 64'(bus.almost_full[v]), 64'(mq[v].size() >= AF));
            end
            chk("dout_vld", 64'(bus.dout_vld), 64'(m_vld));
            chk("dout", 64'(bus.dout), 64'(m_dout));
            chk("ovf_err", 64'(bus.ovf_err), 64'(m_ovf));
            chk("udf_err", 64'(bus.udf_err), 64'(m_udf));
        end
    end

    initial begin
        idle_inputs();
        model_reset();
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_empty", 64'(bus.empty), 64'h3);
        chk("rst_full", 64'(bus.full), 64'h0);
        chk("rst_count", 64'(bus.count), 64'h0);
        chk("rst_dout", 64'(bus.dout), 64'h0);
        chk("rst_vld", 64'(bus.dout_vld), 64'h0);

        cyc(1, 0, 32'hA1, 0, 0, 0);
        cyc(1, 0, 32'hA2, 0, 0, 0);
        cyc(1, 0, 32'hA3, 0, 0, 0);
        cyc(1, 1, 32'hB1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("rd1_dout", 64'(bus.dout), 64'hA1);
        chk("rd1_vld", 64'(bus.dout_vld), 64'h1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("rd2_dout", 64'(bus.dout), 64'hA2);
        chk("rd2_cnt0", 64'(cnt(0)), 64'h1);
        chk("rd2_cnt1", 64'(cnt(1)), 64'h1);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("rd_b1", 64'(bus.dout), 64'hB1);

        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 1, 32'hC0 + 32'(i), 0, 0, 0);
            if (i == AF - 2) chk("af_below", 64'(bus.almost_full[1]), 64'h0);
            if (i == AF - 1) chk("af_at", 64'(bus.almost_full[1]), 64'h1);
        end
        chk("full1", 64'(bus.full[1]), 64'h1);
        cyc(1, 1, 32'hCF, 0, 0, 0);
        chk("ovf_set", 64'(bus.ovf_err), 64'h1);
        chk("ovf_cnt1", 64'(cnt(1)), 64'h8);
        chk("ovf_cnt0", 64'(cnt(0)), 64'h0);

        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 0, 1, 1, 0);
            chk("drain", 64'(bus.dout), 64'hC0 + 64'(i));
        end
        cyc(0, 0, 0, 1, 1, 0);
        chk("udf_set", 64'(bus.udf_err), 64'h1);
        chk("udf_empty", 64'(bus.empty[1]), 64'h1);
        cyc(0, 0, 0, 0, 0, 1);
        chk("udf_clr", 64'(bus.udf_err), 64'h0);
        chk("ovf_clr", 64'(bus.ovf_err), 64'h0);

        cyc(1, 0, 32'h00, 0, 0, 0);
        for (int i = 1; i < 20; i++) begin
            cyc(1, 0, 32'(i), 1, 0, 0);
            chk("wrap_dout", 64'(bus.dout), 64'(i - 1));
            chk("wrap_cnt", 64'(cnt(0)), 64'h1);
        end
        cyc(0, 0, 0, 1, 0, 0);
        chk("wrap_last", 64'(bus.dout), 64'h13);

        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 32'hD0 + 32'(i), 0, 0, 0);
        cyc(1, 0, 32'hEE, 1, 0, 0);
        chk("simul_dout", 64'(bus.dout), 64'hD0);
        chk("simul_ovf", 64'(bus.ovf_err), 64'h1);
        chk("simul_cnt", 64'(cnt(0)), 64'h7);
        cyc(0, 0, 0, 0, 0, 1);

        repeat (1500) begin
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)), $urandom,
                1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)),
                $urandom_range(0, 15) == 0);
        end

        cyc(1, 1, 32'h99, 0, 0, 0);
        cyc(1, 0, 32'h98, 0, 0, 0);
        cyc(1, 0, 32'h97, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_empty", 64'(bus.empty), 64'h3);
        chk("arst_count", 64'(bus.count), 64'h0);
        chk("arst_vld", 64'(bus.dout_vld), 64'h0);
        chk("arst_dout", 64'(bus.dout), 64'h0);
        chk("arst_ovf", 64'(bus.ovf_err), 64'h0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 1, 32'h55, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0);
        chk("post_rst_rd", 64'(bus.dout), 64'h55);
        cyc(0, 0, 0, 0, 0, 0);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
- Multi-channel input buffer for Bi-NoC router ports: NUM_VC independent virtual-channel FIFOs, each DEPTH entries of DATA_WIDTH bits.
- One write port and one read port, each addressed by a VC index.
- Per-VC full, empty, almost-full and occupancy outputs feed the router's credit and arbitration logic.
- Sticky overflow/underflow error flags replace silent drop.

Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH, 8, entries per VC; power of two, >= 2.
- NUM_VC, 2, number of virtual channels; >= 1.
- AF_LEVEL, DEPTH-2, almost_full[v] asserts when count[v] >= AF_LEVEL; range 1..DEPTH.
- Derived localparams: AW = clog2(DEPTH); VW = max(1, clog2(NUM_VC)).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write request.
- wr_vc  in  VW  target VC for the write.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request.
- rd_vc  in  VW  source VC for the read.
- dout  out  DATA_WIDTH  read data.
- dout_vld  out  1  dout updated by an accepted read.
- full  out  NUM_VC  per-VC full.
- empty  out  NUM_VC  per-VC empty.
- almost_full  out  NUM_VC  per-VC occupancy >= AF_LEVEL.
- count  out  NUM_VC*(AW+1)  per-VC occupancy, VC v at bits [v*(AW+1) +: AW+1].
- ovf_err  out  1  sticky: write attempted to a full VC.
- udf_err  out  1  sticky: read attempted from an empty VC.
- clr_err  in  1  synchronous clear of ovf_err and udf_err.

Behaviour:
- Reset (rst_n low, asynchronous): all pointers and counts 0; empty = all 1; full = 0; almost_full = 0 (AF_LEVEL >= 1); dout = 0; dout_vld = 0; ovf_err = 0; udf_err = 0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored flits immediately. The first accepted read after release returns data written after release.
- Per-VC storage: circular buffer. wr_ptr[v] and rd_ptr[v] are AW bits and wrap modulo DEPTH with no special handling. count[v] ranges 0..DEPTH.
- full[v], empty[v] and almost_full[v] are combinational from count[v]:
  - full[v] = (count == DEPTH)
  - empty[v] = (count == 0)
- Write acceptance: wr_en && !full[wr_vc], evaluated on pre-edge state. On accept: mem[wr_vc][wr_ptr] <= din; wr_ptr increments.
- Read acceptance: rd_en && !empty[rd_vc], evaluated on pre-edge state. On accept: dout <= mem[rd_vc][rd_ptr]; rd_ptr increments; dout_vld = 1 for the following cycle.
- Read latency: 1 cycle. dout holds its last value when no read is accepted; dout_vld = 0 in that case.
- Count update per VC: +1 on accepted write only, -1 on accepted read only, unchanged when both or neither.
- Simultaneous write and read to the same VC:
  - Not empty and not full: both accepted; count unchanged.
  - Full: read accepted, write rejected and ovf_err set. There is no pass-through.
  - Empty: write accepted, read rejected and udf_err set. No bypass of din to dout.
- Simultaneous write and read to different VCs are fully independent.
- Rejected writes and reads leave pointers, counts and dout unchanged.
- ovf_err/udf_err priority: setting has priority over clr_err in the same cycle.
- wr_vc/rd_vc >= NUM_VC: the request is ignored and the corresponding error flag is set.

Optional Feature:
- Macro: VC_FIFO_FWFT_EN.
- Defined: first-word-fall-through.
  - dout = mem[rd_vc][rd_ptr[rd_vc]] combinationally.
  - dout_vld = !empty[rd_vc] combinationally.
  - An accepted read advances rd_ptr; the next head appears in the same cycle after the edge.
  - Read latency is 0. dout is undefined-but-stable while dout_vld = 0.
  - Reset value of dout_vld is 1'b0, because empty.
- Undefined: registered 1-cycle read as described in Behaviour.

Test Plan:
- Reset then idle -> empty = all 1, full = 0, count = 0, dout = 0, dout_vld = 0, errors = 0.
- VC0: write 0xA1, 0xA2, 0xA3; VC1: write 0xB1; read VC0 x2 -> dout 0xA1 then 0xA2 with dout_vld; count VC0 = 1, VC1 = 1.
- Fill VC1 with 8 writes (DEPTH = 8) -> almost_full[1] at count 6, full[1] at 8. Ninth write -> rejected, ovf_err = 1, count stays 8, VC0 unaffected.
- Drain VC1 fully, then one more read -> 8 flits in write order, empty[1] = 1, udf_err = 1. clr_err pulse -> udf_err = 0.
- Wrap: 20 interleaved write/read pairs on VC0 with incrementing data 0x00..0x13 -> output sequence identical, count constant, no errors.
- Same-VC simultaneous write+read on full VC0 -> read returns oldest flit, write rejected, ovf_err = 1, count = 8 - 1 = 7. Assert rst_n low mid-stream -> all flags back to reset values asynchronously.
